// File: rtl/piso_shift_serializer.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over valid/ready and
// emits it one bit per enabled clock, with back-to-back loads and no idle bubble.
module piso_shift_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   shreg_shifted;
  logic               head_bit;
  logic               last_edge;
  logic               accept;

  // Shift direction and line bit follow the receiver's bit order.
  always_comb begin
    if (MSB_FIRST) begin
      shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
      head_bit      = shreg_q[WIDTH-1];
    end else begin
      shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
      head_bit      = shreg_q[0];
    end
  end

  // The final enabled edge of a frame doubles as a load slot for the next word.
  assign last_edge  = (state_q == ST_SHIFT) && shift_en && (cnt_q == CNT_W'(1));
  assign load_ready = rst && ((state_q == ST_IDLE) || last_edge);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = load_data;
          cnt_d   = CNT_W'(WIDTH);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (shift_en) begin
          shreg_d = shreg_shifted;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
          if (cnt_q == CNT_W'(1)) begin
            done_d = 1'b1;
            if (accept) begin
              shreg_d = load_data;
              cnt_d   = CNT_W'(WIDTH);
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == ST_SHIFT);
  assign out_valid = busy;
  assign out_bit   = busy && head_bit;
  assign done      = done_q;

endmodule
